// File: rtl/seq_match_pkg.sv
// Shared defaults and helpers for the parametrised sequence matcher.
//   DEF_*      : default parameter values for seq_match_param
//   sat_inc()  : saturating increment of a counter that is `width` bits wide
package seq_match_pkg;

  localparam int unsigned DEF_W     = 2;
  localparam int unsigned DEF_DEPTH = 3;
  localparam int unsigned DEF_CNT_W = 8;

  // Element 0 (first expected symbol) sits in the MSBs.
  localparam logic [DEF_DEPTH*DEF_W-1:0] DEF_PATTERN_INIT = {2'b01, 2'b11, 2'b10};

  // Increment, holding at 2^width-1; supports widths up to 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
    logic [32:0] max_val;
    max_val = (33'd1 << width) - 33'd1;
    if ({1'b0, count} >= max_val) sat_inc = count;
    else                          sat_inc = count + 32'd1;
  endfunction

endpackage

// File: rtl/seq_history.sv
// Symbol history shift register with fill counter.
//   clk, reset_n   : clock, async active-low reset
//   shift          : accept sym this edge (oldest entry dropped)
//   clear          : synchronous fill reset, history contents kept
//   restart        : fill reset after a non-overlapping match
//   sym            : incoming symbol
//   hist_next_c    : history as it will be after this edge, oldest in MSBs
//   fill_next_c    : fill as it will be after this edge, before clear/restart
//   fill           : registered count of valid history symbols, 0..DEPTH
module seq_history
  import seq_match_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           shift,
  input  logic                           clear,
  input  logic                           restart,
  input  logic [W-1:0]                   sym,
  output logic [DEPTH*W-1:0]             hist_next_c,
  output logic [$clog2(DEPTH+1)-1:0]     fill_next_c,
  output logic [$clog2(DEPTH+1)-1:0]     fill
);

  localparam int unsigned HW     = DEPTH * W;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [HW-1:0] hist;

  // Look-ahead view used by the comparator in the same cycle.
  always_comb begin
    hist_next_c = hist;
    fill_next_c = fill;
    if (shift) begin
      hist_next_c = {hist[HW-W-1:0], sym};
      if (fill != FILL_W'(DEPTH)) fill_next_c = fill + FILL_W'(1);
    end
  end

  // A cleared or restarted history keeps stale symbols; fill alone gates matching.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_next_c;
      fill <= (clear || restart) ? '0 : fill_next_c;
    end
  end

endmodule

// File: rtl/seq_match_param.sv
// Programmable sequence detector: pulses match when the last DEPTH accepted
// symbols equal the pattern register, with overlap control and a saturating
// match counter.
//   clk, reset_n        : clock, async active-low reset
//   sym_valid, sym      : symbol stream with valid qualifier
//   overlap_en          : 1 keeps history after a match, 0 restarts it
//   clear               : soft clear of fill, match and count (pattern kept)
//   cfg_we/idx/sym      : pattern element write, element 0 = first expected
//   match               : one-cycle registered pulse per match
//   fill                : valid history symbols, 0..DEPTH
//   match_count         : saturating match count
module seq_match_param
  import seq_match_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter logic [DEPTH*W-1:0] PATTERN_INIT = (DEPTH*W)'(DEF_PATTERN_INIT)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sym_valid,
  input  logic [W-1:0]                 sym,
  input  logic                         overlap_en,
  input  logic                         clear,
  input  logic                         cfg_we,
  input  logic [$clog2(DEPTH)-1:0]     cfg_idx,
  input  logic [W-1:0]                 cfg_sym,
  output logic                         match,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic [CNT_W-1:0]             match_count
);

  localparam int unsigned HW     = DEPTH * W;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [HW-1:0]     pattern;
  logic [HW-1:0]     hist_next_c;
  logic [FILL_W-1:0] fill_next_c;
  logic              accept_c;
  logic              match_c;
  logic              restart_c;

  // clear wins over sym_valid; the symbol in a clear cycle is dropped.
  assign accept_c  = sym_valid & ~clear;
  // Compare uses the pattern as it stands before any same-edge cfg write.
  assign match_c   = accept_c && (fill_next_c == FILL_W'(DEPTH)) && (hist_next_c == pattern);
  assign restart_c = match_c & ~overlap_en;

  seq_history #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_history (
    .clk         (clk),
    .reset_n     (reset_n),
    .shift       (accept_c),
    .clear       (clear),
    .restart     (restart_c),
    .sym         (sym),
    .hist_next_c (hist_next_c),
    .fill_next_c (fill_next_c),
    .fill        (fill)
  );

  // Pattern element writes; indices >= DEPTH match no element and are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern <= PATTERN_INIT;
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cfg_idx == IDX_W'(i)) pattern[(DEPTH-1-i)*W +: W] <= cfg_sym;
      end
    end
  end

  // Match pulse and saturating counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match       <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= match_c;
      if (match_c) match_count <= CNT_W'(sat_inc(32'(match_count), CNT_W));
    end
  end

endmodule

// File: tb/tb_seq_match_param.sv
// Self-checking bench for seq_match_param: directed vector table, hand-written
// reset / same-edge-config sequences, and randomized traffic against a
// queue-based reference model. A second instance with CNT_W=2 shares all
// inputs to observe counter saturation.
module tb_seq_match_param;

  logic       clk;
  logic       reset_n;
  logic       sym_valid;
  logic [1:0] sym;
  logic       overlap_en;
  logic       clear;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [1:0] cfg_sym;
  logic       match,   match_s;
  logic [1:0] fill,    fill_s;
  logic [7:0] match_count;
  logic [1:0] count_s;

  int errors = 0;
  int checks = 0;

  seq_match_param #(.W(2), .DEPTH(3), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym(sym),
    .overlap_en(overlap_en), .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sym(cfg_sym), .match(match), .fill(fill), .match_count(match_count)
  );

  seq_match_param #(.W(2), .DEPTH(3), .CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym(sym),
    .overlap_en(overlap_en), .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sym(cfg_sym), .match(match_s), .fill(fill_s), .match_count(count_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       ov;
    logic       cl;
    logic       we;
    logic [1:0] idx;
    logic [1:0] cs;
    logic       m;
    int         f;
    int         c;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [1:0] s, input logic ov, input logic cl,
                     input logic we, input logic [1:0] idx, input logic [1:0] cs,
                     input logic m, input int f, input int c);
    vec_t r;
    r.v = v; r.s = s; r.ov = ov; r.cl = cl; r.we = we; r.idx = idx; r.cs = cs;
    r.m = m; r.f = f; r.c = c;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle just after it.
  task automatic drive(input logic v, input logic [1:0] s, input logic ov, input logic cl,
                       input logic we, input logic [1:0] idx, input logic [1:0] cs);
    sym_valid = v; sym = s; overlap_en = ov; clear = cl;
    cfg_we = we; cfg_idx = idx; cfg_sym = cs;
    @(posedge clk);
    #1;
  endtask

  // Reference model: last accepted symbols kept in a queue, counts as integers.
  logic [1:0] m_pat [3];
  logic [1:0] m_q [$];
  int         m_cnt;
  int         m_cnt_s;
  int         m_match;

  task automatic model_reset();
    m_pat[0] = 2'b01; m_pat[1] = 2'b11; m_pat[2] = 2'b10;
    m_q.delete();
    m_cnt = 0; m_cnt_s = 0; m_match = 0;
  endtask

  task automatic model_step();
    int hit;
    if (clear) begin
      m_q.delete();
      m_match = 0; m_cnt = 0; m_cnt_s = 0;
    end else if (sym_valid) begin
      m_q.push_back(sym);
      if (m_q.size() > 3) void'(m_q.pop_front());
      hit = 0;
      if (m_q.size() == 3) begin
        hit = 1;
        for (int i = 0; i < 3; i++) if (m_q[i] != m_pat[i]) hit = 0;
      end
      m_match = hit;
      if (hit != 0) begin
        m_cnt   = (m_cnt   < 255) ? m_cnt + 1   : 255;
        m_cnt_s = (m_cnt_s < 3)   ? m_cnt_s + 1 : 3;
        if (!overlap_en) m_q.delete();
      end
    end else begin
      m_match = 0;
    end
    if (cfg_we && int'(cfg_idx) < 3) m_pat[cfg_idx] = cfg_sym;
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0;
    sym_valid = 1'b0; sym = 2'b00; overlap_en = 1'b1; clear = 1'b0;
    cfg_we = 1'b0; cfg_idx = 2'd0; cfg_sym = 2'b00;

    // Default pattern 01,11,10.
    add(1,1,1,0,0,0,0, 0,1,0);
    add(1,3,1,0,0,0,0, 0,2,0);
    add(1,2,1,0,0,0,0, 1,3,1);
    add(0,0,1,0,0,0,0, 0,3,1);
    add(0,0,1,1,0,0,0, 0,0,0);
    // Pattern 01,01,01; idx 3 write must be ignored.
    add(0,0,1,0,1,0,1, 0,0,0);
    add(0,0,1,0,1,1,1, 0,0,0);
    add(0,0,1,0,1,2,1, 0,0,0);
    add(0,0,1,0,1,3,2, 0,0,0);
    // Overlapping: five 01.
    add(1,1,1,0,0,0,0, 0,1,0);
    add(1,1,1,0,0,0,0, 0,2,0);
    add(1,1,1,0,0,0,0, 1,3,1);
    add(1,1,1,0,0,0,0, 1,3,2);
    add(1,1,1,0,0,0,0, 1,3,3);
    add(0,0,1,0,0,0,0, 0,3,3);
    add(0,0,1,1,0,0,0, 0,0,0);
    // Non-overlapping: six 01.
    add(1,1,0,0,0,0,0, 0,1,0);
    add(1,1,0,0,0,0,0, 0,2,0);
    add(1,1,0,0,0,0,0, 1,0,1);
    add(1,1,0,0,0,0,0, 0,1,1);
    add(1,1,0,0,0,0,0, 0,2,1);
    add(1,1,0,0,0,0,0, 1,0,2);
    add(0,0,1,1,0,0,0, 0,0,0);
    // Restore 01,11,10; gaps then clear discards the in-flight symbol.
    add(0,0,1,0,1,0,1, 0,0,0);
    add(0,0,1,0,1,1,3, 0,0,0);
    add(0,0,1,0,1,2,2, 0,0,0);
    add(1,1,1,0,0,0,0, 0,1,0);
    add(0,0,1,0,0,0,0, 0,1,0);
    add(0,0,1,0,0,0,0, 0,1,0);
    add(0,0,1,0,0,0,0, 0,1,0);
    add(1,3,1,0,0,0,0, 0,2,0);
    add(1,3,1,1,0,0,0, 0,0,0);
    add(1,2,1,0,0,0,0, 0,1,0);
    // Saturation: pattern 00,00,00, eight 00.
    add(0,0,1,1,0,0,0, 0,0,0);
    add(0,0,1,0,1,0,0, 0,0,0);
    add(0,0,1,0,1,1,0, 0,0,0);
    add(0,0,1,0,1,2,0, 0,0,0);
    add(1,0,1,0,0,0,0, 0,1,0);
    add(1,0,1,0,0,0,0, 0,2,0);
    for (int k = 1; k <= 6; k++) add(1,0,1,0,0,0,0, 1,3,k);

    repeat (2) @(posedge clk);
    #1;
    chk("reset match", match, 0);
    chk("reset fill", fill, 0);
    chk("reset count", match_count, 0);
    chk("reset count_s", count_s, 0);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].s, vecs[k].ov, vecs[k].cl, vecs[k].we, vecs[k].idx, vecs[k].cs);
      chk($sformatf("vec%0d match", k), match, vecs[k].m);
      chk($sformatf("vec%0d fill", k), fill, vecs[k].f);
      chk($sformatf("vec%0d count", k), match_count, vecs[k].c);
      chk($sformatf("vec%0d count_s", k), count_s, (vecs[k].c < 3) ? vecs[k].c : 3);
      chk($sformatf("vec%0d match_s", k), match_s, vecs[k].m);
    end

    // Asynchronous reset mid-cycle while count is non-zero.
    drive(1,2'b01,1,0,0,0,0);
    drive(1,2'b11,1,0,0,0,0);
    #3 reset_n = 1'b0;
    #1;
    chk("async fill", fill, 0);
    chk("async match", match, 0);
    chk("async count", match_count, 0);
    chk("async count_s", count_s, 0);
    #1 reset_n = 1'b1;
    drive(1,2'b10,1,0,0,0,0);
    chk("post-reset lone 10 match", match, 0);
    chk("post-reset fill", fill, 1);
    drive(1,2'b01,1,0,0,0,0);
    drive(1,2'b11,1,0,0,0,0);
    chk("post-reset no early match", match, 0);
    // Same-edge cfg write must not affect this edge's compare.
    drive(1,2'b10,1,0,1,2'd2,2'b11);
    chk("old pattern match", match, 1);
    chk("old pattern count", match_count, 1);
    drive(1,2'b01,1,0,0,0,0);
    drive(1,2'b11,1,0,0,0,0);
    chk("new pattern partial", match, 0);
    drive(1,2'b11,1,0,0,0,0);
    chk("new pattern match", match, 1);
    chk("new pattern count", match_count, 2);

    // Randomized traffic against the model.
    drive(0,0,1,0,0,0,0);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      logic       v, ov, cl, we;
      logic [1:0] s, idx, cs;
      v   = ($urandom_range(0, 9) < 7);
      s   = 2'($urandom_range(0, 3));
      ov  = 1'($urandom_range(0, 1));
      cl  = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 32) == 0);
      idx = 2'($urandom_range(0, 3));
      cs  = 2'($urandom_range(0, 3));
      drive(v, s, ov, cl, we, idx, cs);
      model_step();
      chk($sformatf("rnd%0d match", n), match, m_match);
      chk($sformatf("rnd%0d fill", n), fill, m_q.size());
      chk($sformatf("rnd%0d count", n), match_count, m_cnt);
      chk($sformatf("rnd%0d count_s", n), count_s, m_cnt_s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_match_param.md
Name: seq_match_param

Overview:
- Parametrised successor to the team's fixed 4-state sequence-detector FSMs.
- Watches a stream of W-bit symbols and flags when the last DEPTH accepted symbols equal a runtime-programmable pattern.
- Supports overlapping and non-overlapping match modes, input gaps (valid qualifier) and a saturating match counter.
- Sits between board switch/debounce logic and LED/status outputs, or between any symbol producer and a control FSM.

Parameters:
- W, 2, symbol width in bits (>=1).
- DEPTH, 3, pattern length in symbols (>=2).
- CNT_W, 8, match counter width (>=1).
- PATTERN_INIT, {2'b01,2'b11,2'b10}, reset pattern as DEPTH*W bits; element 0 (first expected symbol) in the MSBs.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sym_valid  in  1  sym is accepted on this edge.
- sym  in  W  input symbol.
- overlap_en  in  1  1 = overlapping matches, 0 = history restarts after each match.
- clear  in  1  synchronous soft clear of fill, match and count; pattern is kept.
- cfg_we  in  1  pattern element write enable.
- cfg_idx  in  $clog2(DEPTH)  element index, 0 = first expected symbol.
- cfg_sym  in  W  element value.
- match  out  1  one-cycle pulse per detected match.
- fill  out  $clog2(DEPTH+1)  number of valid history symbols, 0..DEPTH.
- match_count  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (reset_n=0, any time, asynchronous):
  - history cleared to 0; fill=0, match=0, match_count=0.
  - pattern loads PATTERN_INIT.
  - Recovery: the first accepting edge after reset_n rises acts as if from an empty history.
- Accepting edge (sym_valid=1, clear=0):
  - history shifts; sym becomes the newest entry and the oldest is dropped.
  - fill_next = min(fill+1, DEPTH).
- Match condition:
  - fill_next==DEPTH, and history_next oldest..newest equals pattern[0..DEPTH-1].
  - Compared against the pattern register value before any same-edge cfg write.
- Match latency: match is registered; it goes high the cycle after the accepting edge and stays high exactly one cycle. It is 0 on every edge with no match.
- match_count increments on the same edge match is set, and saturates at 2^CNT_W-1. match still pulses at saturation.
- overlap_en=1: history and fill are kept after a match, so the next symbol can complete another match.
- overlap_en=0: on a match edge fill is set to 0, so at least DEPTH further symbols are needed for the next match. overlap_en is sampled per edge.
- sym_valid=0: history, fill and match_count hold; match=0. Gaps never break a partial sequence.
- clear=1: fill=0, match=0, match_count=0. clear has priority over sym_valid, and the symbol in that cycle is discarded. Pattern is unaffected.
- cfg_we=1: pattern[cfg_idx] <= cfg_sym, visible from the next edge. cfg_idx>=DEPTH is ignored. A cfg write is independent of clear and sym_valid and does not alter fill.
- Internal states: fill 0..DEPTH-1 = PARTIAL, DEPTH = ARMED. Transitions are as above; there are no other states.

Decomposition:
- Package seq_match_pkg:
  - default parameter constants (W, DEPTH, CNT_W, PATTERN_INIT).
  - function sat_inc(count, width).
- Sub-module seq_history:
  - W/DEPTH shift register with fill counter, async active-low reset, clear and restart inputs.
  - Outputs the flattened history and fill.
- The top level holds the pattern registers, the comparator, match and count.

Test Plan:
- Defaults; sym 01,11,10 on consecutive edges -> match=1 only in the cycle after the third edge; match_count=1; fill=3.
- Pattern set to 01,01,01, overlap_en=1, five consecutive 01 -> match pulses after edges 3, 4 and 5; count=3.
- Same stimulus with overlap_en=0 -> single pulse after edge 3, fill=0 after it; sixth 01 -> second pulse; count=2.
- Defaults; 01, three idle cycles, 11, clear pulse, 10 -> no match; fill=1 after the final edge; count=0.
- CNT_W=2, overlap_en=1, pattern 00,00,00, eight consecutive 00 -> six pulses; match_count sticks at 3.
- Drive 01,11, assert reset_n=0 mid-cycle -> fill/match/count go to 0 immediately without a clock; after release, 10 alone -> no match. Then 01,11,10 with cfg_we rewriting idx2 to 11 on the 10 edge -> match (old pattern used on that edge).
